// File: rtl/alu_tx_pkg.sv
// Shared types and default constants for the ALU result UART transmitter.
package alu_tx_pkg;

  localparam int NB_OUT_DEF       = 16;
  localparam int NB_DATA_DEF      = 8;
  localparam int CLKS_PER_BIT_DEF = 868;
  localparam int BYTES_PER_RESULT = NB_OUT_DEF / NB_DATA_DEF;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: one-cycle tick every CLKS_PER_BIT cycles, restartable via i_clear.
module baud_tick_gen #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign o_tick = (cnt_q == CW'(CLKS_PER_BIT - 1));

  // Next count: restart on clear or wrap, otherwise advance.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear || o_tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_result_tx.sv
// Latches a 16-bit ALU result and sends it LSB byte first as UART frames.
// Optional even parity (8E1) when ALU_RESULT_TX_PARITY_EN is defined; 8N1 otherwise.
module alu_result_tx
  import alu_tx_pkg::*;
#(
  parameter int NB_OUT       = NB_OUT_DEF,
  parameter int NB_DATA      = NB_DATA_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic signed [NB_OUT-1:0] i_result,
  input  logic                     i_valid,
  output logic                     o_tx,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int BYTES = NB_OUT / NB_DATA;
  localparam int BITW  = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam int BYTW  = (BYTES > 1) ? $clog2(BYTES) : 1;

  tx_state_e         state_q, state_d;
  logic [BITW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BYTW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [NB_OUT-1:0] shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef ALU_RESULT_TX_PARITY_EN
  logic              par_q, par_d;
`endif
  logic              accept_s;
  logic              tick_s;

  assign accept_s = (state_q == ST_IDLE) && i_valid;

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk  (i_clk),
    .i_reset(i_reset),
    .i_clear(accept_s),
    .o_tick (tick_s)
  );

  // Next-state and registered-output logic; tx_d is the line level for the next bit.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef ALU_RESULT_TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          shift_d    = i_result;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          state_d    = ST_START;
        end else begin
          tx_d = 1'b1;
        end
      end
      ST_START: begin
        if (tick_s) begin
          state_d   = ST_DATA;
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = '0;
`ifdef ALU_RESULT_TX_PARITY_EN
          par_d     = shift_q[0];
`endif
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (tick_s && (bit_cnt_q == BITW'(NB_DATA - 1))) begin
`ifdef ALU_RESULT_TX_PARITY_EN
          state_d = ST_PARITY;
          tx_d    = par_q;
`else
          state_d = ST_STOP;
          tx_d    = 1'b1;
`endif
        end else if (tick_s) begin
          bit_cnt_d = bit_cnt_q + BITW'(1);
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
`ifdef ALU_RESULT_TX_PARITY_EN
          par_d     = par_q ^ shift_q[0];
`endif
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef ALU_RESULT_TX_PARITY_EN
      ST_PARITY: begin
        if (tick_s) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (tick_s && (byte_cnt_q == BYTW'(BYTES - 1))) begin
          state_d    = ST_IDLE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          byte_cnt_d = '0;
        end else if (tick_s) begin
          // Next byte's start bit follows immediately, no inter-frame gap.
          byte_cnt_d = byte_cnt_q + BYTW'(1);
          state_d    = ST_START;
          tx_d       = 1'b0;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef ALU_RESULT_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef ALU_RESULT_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign o_tx   = tx_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule
